// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, coin values and dispenser state type
package vend_pkg;

    localparam int CENTS_W_DEF = 12;
    localparam int N_COINS     = 5;

    localparam logic [2:0] COIN_DOLLAR  = 3'd0;
    localparam logic [2:0] COIN_HALF    = 3'd1;
    localparam logic [2:0] COIN_QUARTER = 3'd2;
    localparam logic [2:0] COIN_DIME    = 3'd3;
    localparam logic [2:0] COIN_NICKEL  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } state_e;

    // Value in cents of the coin identified by a coin code.
    function automatic int unsigned coin_value(input logic [2:0] code);
        case (code)
            COIN_DOLLAR:  coin_value = 100;
            COIN_HALF:    coin_value = 50;
            COIN_QUARTER: coin_value = 25;
            COIN_DIME:    coin_value = 10;
            COIN_NICKEL:  coin_value = 5;
            default:      coin_value = 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_priority_sel.sv
// rtl/coin_priority_sel.sv - picks the highest-value denomination with coins left
module coin_priority_sel
    import vend_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic [COUNT_W-1:0] dollars_i,
    input  logic [COUNT_W-1:0] half_dollars_i,
    input  logic [COUNT_W-1:0] quarters_i,
    input  logic [COUNT_W-1:0] dimes_i,
    input  logic [COUNT_W-1:0] nickels_i,
    output logic               valid_o,
    output logic [2:0]         code_o
);

    // Fixed priority, largest coin first; valid_o low means nothing left to pay.
    always_comb begin
        valid_o = 1'b1;
        code_o  = COIN_DOLLAR;
        if (dollars_i != '0) begin
            code_o = COIN_DOLLAR;
        end else if (half_dollars_i != '0) begin
            code_o = COIN_HALF;
        end else if (quarters_i != '0) begin
            code_o = COIN_QUARTER;
        end else if (dimes_i != '0) begin
            code_o = COIN_DIME;
        end else if (nickels_i != '0) begin
            code_o = COIN_NICKEL;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out coin counts one at a time over a hopper handshake
module change_dispenser
    import vend_pkg::*;
#(
    parameter int COUNT_W       = 4,
    parameter int CENTS_W       = CENTS_W_DEF,
    parameter int EJECT_TIMEOUT = 255,
    parameter int GAP_CYCLES    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] dollars,
    input  logic [COUNT_W-1:0] half_dollars,
    input  logic [COUNT_W-1:0] quarters,
    input  logic [COUNT_W-1:0] dimes,
    input  logic [COUNT_W-1:0] nickels,
    output logic               eject_req,
    output logic [2:0]         coin_sel,
    input  logic               eject_ack,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [CENTS_W-1:0] dispensed_cents
);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   rem_q [N_COINS];
    logic [COUNT_W-1:0]   rem_d [N_COINS];
    logic [2:0]           sel_q, sel_d;
    logic [CENTS_W-1:0]   cents_q, cents_d;
    logic                 fault_q, fault_d;
    logic [15:0]          cnt_q, cnt_d;   // REQ timeout counter, reused as GAP counter

    logic                 pri_valid;
    logic [2:0]           pri_code;

    coin_priority_sel #(.COUNT_W(COUNT_W)) u_sel (
        .dollars_i      (rem_q[0]),
        .half_dollars_i (rem_q[1]),
        .quarters_i     (rem_q[2]),
        .dimes_i        (rem_q[3]),
        .nickels_i      (rem_q[4]),
        .valid_o        (pri_valid),
        .code_o         (pri_code)
    );

    assign eject_req       = (state_q == ST_REQ);
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign coin_sel        = sel_q;
    assign fault           = fault_q;
    assign dispensed_cents = cents_q;

    // State register plus job bookkeeping; reset discards any unpaid remainder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < N_COINS; i++) rem_q[i] <= '0;
            sel_q   <= '0;
            cents_q <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            cents_q <= cents_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: select, request, wait out the gap, repeat until empty or timed out.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        cents_d = cents_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d[0] = dollars;
                    rem_d[1] = half_dollars;
                    rem_d[2] = quarters;
                    rem_d[3] = dimes;
                    rem_d[4] = nickels;
                    cents_d  = '0;
                    fault_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                cnt_d = '0;
                if (pri_valid) begin
                    sel_d   = pri_code;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                // An ack on the timeout edge still pays the coin.
                if (eject_ack) begin
                    if (rem_q[sel_q] != '0) begin
                        rem_d[sel_q] = rem_q[sel_q] - 1'b1;
                    end
                    cents_d = cents_q + CENTS_W'(coin_value(sel_q));
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;
                end else if (cnt_q == 16'(EJECT_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SELECT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset;

    logic        start_a, ack_a;
    logic [3:0]  dol_a, half_a, qtr_a, dime_a, nick_a;
    logic        req_a, busy_a, done_a, fault_a;
    logic [2:0]  sel_a;
    logic [11:0] cents_a;

    logic        start_b;
    logic [3:0]  dol_b, half_b, qtr_b, dime_b, nick_b;
    logic        req_b, busy_b, done_b, fault_b;
    logic [2:0]  sel_b;
    logic [11:0] cents_b;

    int checks   = 0;
    int failures = 0;

    int ack_mode = 0;
    logic req_prev = 1'b0;
    int req_cycles = 0;
    int req_rises  = 0;
    int done_cnt   = 0;
    int seq_a[$];
    int seq_b[$];

    always #5 clk = ~clk;

    change_dispenser dut_a (
        .clk             (clk),
        .reset           (reset),
        .start           (start_a),
        .dollars         (dol_a),
        .half_dollars    (half_a),
        .quarters        (qtr_a),
        .dimes           (dime_a),
        .nickels         (nick_a),
        .eject_req       (req_a),
        .coin_sel        (sel_a),
        .eject_ack       (ack_a),
        .busy            (busy_a),
        .done            (done_a),
        .fault           (fault_a),
        .dispensed_cents (cents_a)
    );

    change_dispenser #(.GAP_CYCLES(0)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .start           (start_b),
        .dollars         (dol_b),
        .half_dollars    (half_b),
        .quarters        (qtr_b),
        .dimes           (dime_b),
        .nickels         (nick_b),
        .eject_req       (req_b),
        .coin_sel        (sel_b),
        .eject_ack       (1'b1),
        .busy            (busy_b),
        .done            (done_b),
        .fault           (fault_b),
        .dispensed_cents (cents_b)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Hopper model and activity recorder; ack_mode 1 acks on the second REQ cycle.
    always @(negedge clk) begin
        if (ack_mode == 1) ack_a = req_a && req_prev;
        else               ack_a = 1'b0;
        if (req_a && ack_a)    seq_a.push_back(int'(sel_a));
        if (req_a)             req_cycles++;
        if (req_a && !req_prev) req_rises++;
        if (done_a)            done_cnt++;
        req_prev = req_a;
        if (req_b)             seq_b.push_back(int'(sel_b));
    end

    task automatic start_job(input logic [3:0] d, input logic [3:0] h, input logic [3:0] q,
                             input logic [3:0] dm, input logic [3:0] n);
        @(negedge clk); #1;
        req_cycles = 0; req_rises = 0; done_cnt = 0; seq_a.delete();
        dol_a = d; half_a = h; qtr_a = q; dime_a = dm; nick_a = n;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_a && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (!done_a) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int errs;
        int k;
        reset = 1'b0; start_a = 0; start_b = 0; ack_a = 0;
        {dol_a, half_a, qtr_a, dime_a, nick_a} = '0;
        {dol_b, half_b, qtr_b, dime_b, nick_b} = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",   int'(req_a), 0);
        check("rst_busy",  int'(busy_a), 0);
        check("rst_done",  int'(done_a), 0);
        check("rst_fault", int'(fault_a), 0);
        check("rst_sel",   int'(sel_a), 0);
        check("rst_cents", int'(cents_a), 0);
        reset = 1'b1;

        // 1/1/1/1/0 with delayed ack: 185 cents, descending order
        ack_mode = 1;
        start_job(4'd1, 4'd1, 4'd1, 4'd1, 4'd0);
        check("t1_busy", int'(busy_a), 1);
        wait_done_a("t1", 200);
        check("t1_cents", int'(cents_a), 185);
        check("t1_fault", int'(fault_a), 0);
        @(negedge clk); #1;
        check("t1_busy_after", int'(busy_a), 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_nseq", seq_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seq_a.size()) check($sformatf("t1_sel%0d", i), seq_a[i], i);
        end

        // all zero: done two edges after start, no request
        start_job(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("t2_done_early", int'(done_a), 0);
        @(negedge clk); #1;
        check("t2_done", int'(done_a), 1);
        check("t2_cents", int'(cents_a), 0);
        @(negedge clk); #1;
        check("t2_busy_after", int'(busy_a), 0);
        check("t2_req_cycles", req_cycles, 0);

        // no ack: 255 request cycles then fault
        ack_mode = 0;
        start_job(4'd0, 4'd0, 4'd0, 4'd0, 4'd2);
        wait_done_a("t3", 400);
        check("t3_fault", int'(fault_a), 1);
        check("t3_cents", int'(cents_a), 0);
        check("t3_req_cycles", req_cycles, 255);
        @(negedge clk); #1;
        check("t3_busy_after", int'(busy_a), 0);
        check("t3_fault_hold", int'(fault_a), 1);
        check("t3_done_cnt", done_cnt, 1);

        // start while busy is ignored; new start clears fault
        ack_mode = 1;
        start_job(4'd1, 4'd0, 4'd0, 4'd0, 4'd1);
        check("t5_fault_clr", int'(fault_a), 0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        dol_a = 4'd15; half_a = 4'd15; qtr_a = 4'd15; dime_a = 4'd15; nick_a = 4'd15;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
        wait_done_a("t5", 200);
        check("t5_cents", int'(cents_a), 105);
        @(negedge clk); #1;
        check("t5_done_cnt", done_cnt, 1);
        check("t5_nseq", seq_a.size(), 2);
        if (seq_a.size() == 2) begin
            check("t5_sel0", seq_a[0], 0);
            check("t5_sel1", seq_a[1], 4);
        end

        // reset during second request aborts the job
        start_job(4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        k = 0;
        while (req_rises < 2 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("t4_second_req", req_rises, 2);
        check("t4_req_before", int'(req_a), 1);
        reset = 1'b0;
        #1;
        check("t4_req",   int'(req_a), 0);
        check("t4_busy",  int'(busy_a), 0);
        check("t4_sel",   int'(sel_a), 0);
        check("t4_cents", int'(cents_a), 0);
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        check("t4_idle", int'(busy_a), 0);
        start_job(4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
        wait_done_a("t4b", 200);
        check("t4b_cents", int'(cents_a), 10);
        check("t4b_fault", int'(fault_a), 0);

        // GAP_CYCLES=0, ack tied high, full load
        @(negedge clk); #1;
        seq_b.delete();
        dol_b = 4'd15; half_b = 4'd15; qtr_b = 4'd15; dime_b = 4'd15; nick_b = 4'd15;
        start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        if (!done_b) check("t6_timeout", 0, 1);
        check("t6_cents", int'(cents_b), 2850);
        check("t6_fault", int'(fault_b), 0);
        check("t6_nseq", seq_b.size(), 75);
        errs = 0;
        for (int i = 0; i < seq_b.size(); i++) begin
            if (seq_b[i] != i / 15) errs++;
        end
        check("t6_order_errs", errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
